time_manager_nch: RTL and testbench

- Parametrised successor to the two-input time manager.
- Reduces N per-channel proposed next-event times to the global minimum and reports which channel owns it.
- Registers the emulator's current time and gates time advance through a run/pause/single-step/stop-time control FSM.
- Sits at the top of the emulation core; feeds time_curr and advance to all channel models.

---
 rtl/time_package.sv | 18 +
 rtl/time_min_tree.sv | 56 +++++
 rtl/time_manager_nch.sv | 139 +++++++++++++
 tb/tb_time_manager_nch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_package.sv
// Shared time types for the emulation core: TIME_FORMAT, the all-ones
// sentinel and the time-manager FSM state encoding.
package time_package;

    localparam int TIME_FORMAT_BITS = 32;

    typedef logic [TIME_FORMAT_BITS-1:0] TIME_FORMAT;

    localparam TIME_FORMAT TIME_MAX = '1;

    typedef enum logic [1:0] {
        TM_IDLE  = 2'd0,
        TM_RUN   = 2'd1,
        TM_PAUSE = 2'd2,
        TM_DONE  = 2'd3
    } tm_state_t;

endpackage

// File: rtl/time_min_tree.sv
// Combinational min-reduction over N channel times. Disabled channels read as
// all-ones; ties keep the left (lower-index) operand. Recursive generate tree.
module time_min_tree #(
    parameter int N         = 4,
    parameter int TIME_BITS = 32,
    parameter int IDX_W     = 2
) (
    input  logic [N*TIME_BITS-1:0] i_val,
    input  logic [N-1:0]           i_en,
    output logic [TIME_BITS-1:0]   o_min,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_any
);

    generate
        if (N == 1) begin : g_leaf
            assign o_min = i_en[0] ? i_val : {TIME_BITS{1'b1}};
            assign o_idx = '0;
            assign o_any = i_en[0];
        end else begin : g_node
            localparam int L = N / 2;
            localparam int R = N - L;

            logic [TIME_BITS-1:0] w_min_l;
            logic [TIME_BITS-1:0] w_min_r;
            logic [IDX_W-1:0]     w_idx_l;
            logic [IDX_W-1:0]     w_idx_r;
            logic                 w_any_l;
            logic                 w_any_r;
            logic                 w_take_l;

            time_min_tree #(.N(L), .TIME_BITS(TIME_BITS), .IDX_W(IDX_W)) u_left (
                .i_val (i_val[L*TIME_BITS-1:0]),
                .i_en  (i_en[L-1:0]),
                .o_min (w_min_l),
                .o_idx (w_idx_l),
                .o_any (w_any_l)
            );

            time_min_tree #(.N(R), .TIME_BITS(TIME_BITS), .IDX_W(IDX_W)) u_right (
                .i_val (i_val[N*TIME_BITS-1:L*TIME_BITS]),
                .i_en  (i_en[N-1:L]),
                .o_min (w_min_r),
                .o_idx (w_idx_r),
                .o_any (w_any_r)
            );

            // <= keeps the lower-index side on equal values, including all-ones.
            assign w_take_l = (w_min_l <= w_min_r);
            assign o_min    = w_take_l ? w_min_l : w_min_r;
            assign o_idx    = w_take_l ? w_idx_l : (w_idx_r + IDX_W'(L));
            assign o_any    = w_any_l | w_any_r;
        end
    endgenerate

endmodule

// File: rtl/time_manager_nch.sv
// N-channel time manager: global next-event minimum plus run/pause/step/stop
// control of the emulator's current time. Optional checks: TIME_MANAGER_NCH_CHECK_EN.
module time_manager_nch
    import time_package::*;
#(
    parameter int N         = 4,
    parameter int TIME_BITS = 32,
    parameter int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic [TIME_BITS-1:0] time_in [N],
    input  logic [N-1:0]         chan_en,
    input  logic                 run,
    input  logic                 step,
    input  logic [TIME_BITS-1:0] stop_time,
    output logic [TIME_BITS-1:0] time_next,
    output logic [IDX_W-1:0]     next_idx,
    output logic                 any_en,
    output logic [TIME_BITS-1:0] time_curr,
    output logic                 advance,
    output logic                 done,
    output logic [1:0]           state
`ifdef TIME_MANAGER_NCH_CHECK_EN
    ,
    output logic                 mono_err,
    output logic [31:0]          step_count
`endif
);

    logic [N*TIME_BITS-1:0] w_time_flat;
    logic [TIME_BITS-1:0]   w_min;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_any;
    logic                   w_upd;
    logic                   w_stop;

    tm_state_t              r_state;
    logic [TIME_BITS-1:0]   r_time_curr;
    logic                   r_advance;
    logic                   r_done;

    generate
        for (genvar g = 0; g < N; g++) begin : g_flat
            assign w_time_flat[g*TIME_BITS +: TIME_BITS] = time_in[g];
        end
    endgenerate

    time_min_tree #(.N(N), .TIME_BITS(TIME_BITS), .IDX_W(IDX_W)) u_min_tree (
        .i_val (w_time_flat),
        .i_en  (chan_en),
        .o_min (w_min),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Leaving RUN because run dropped is not an update; in PAUSE a step updates
    // exactly once even when run is also high.
    assign w_upd  = w_any & (((r_state == TM_RUN) & run) | ((r_state == TM_PAUSE) & step));
    assign w_stop = w_upd & (w_min >= stop_time);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state     <= TM_IDLE;
            r_time_curr <= '0;
            r_advance   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_advance <= w_upd;
            if (w_upd) begin
                r_time_curr <= w_min;
            end
            case (r_state)
                TM_IDLE: begin
                    if (run) begin
                        r_state <= TM_RUN;
                    end else if (step) begin
                        r_state <= TM_PAUSE;
                    end
                end
                TM_RUN: begin
                    if (w_stop) begin
                        r_state <= TM_DONE;
                        r_done  <= 1'b1;
                    end else if (!run) begin
                        r_state <= TM_PAUSE;
                    end
                end
                TM_PAUSE: begin
                    if (w_stop) begin
                        r_state <= TM_DONE;
                        r_done  <= 1'b1;
                    end else if (run) begin
                        r_state <= TM_RUN;
                    end
                end
                default: begin
                    r_state <= TM_DONE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    assign time_next = w_min;
    assign next_idx  = w_idx;
    assign any_en    = w_any;
    assign time_curr = r_time_curr;
    assign advance   = r_advance;
    assign done      = r_done;
    assign state     = r_state;

`ifdef TIME_MANAGER_NCH_CHECK_EN
    logic        r_mono_err;
    logic [31:0] r_step_count;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_mono_err   <= 1'b0;
            r_step_count <= '0;
        end else if (w_upd) begin
            if (w_min < r_time_curr) begin
                r_mono_err <= 1'b1;
            end
            if (r_step_count != 32'hFFFF_FFFF) begin
                r_step_count <= r_step_count + 32'd1;
            end
        end
    end

    assign mono_err   = r_mono_err;
    assign step_count = r_step_count;

`ifndef SYNTHESIS
    a_time_monotonic: assert property (@(posedge clk_sys) disable iff (rst) !$rose(r_mono_err));
`endif
`endif

endmodule

// File: tb/tb_time_manager_nch.sv
// Bench for time_manager_nch: reduction vector table, hand-written FSM
// sequences, and randomized traffic against a behavioural model.
module tb_time_manager_nch;

    localparam int N  = 4;
    localparam int TB = 32;
    localparam int IW = 2;

    logic          clk_sys = 1'b0;
    logic          rst;
    logic [TB-1:0] time_in [N];
    logic [N-1:0]  chan_en;
    logic          run;
    logic          step;
    logic [TB-1:0] stop_time;
    logic [TB-1:0] time_next;
    logic [IW-1:0] next_idx;
    logic          any_en;
    logic [TB-1:0] time_curr;
    logic          advance;
    logic          done;
    logic [1:0]    state;

    int n_pass  = 0;
    int n_total = 0;

    time_manager_nch #(.N(N), .TIME_BITS(TB)) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .time_in   (time_in),
        .chan_en   (chan_en),
        .run       (run),
        .step      (step),
        .stop_time (stop_time),
        .time_next (time_next),
        .next_idx  (next_idx),
        .any_en    (any_en),
        .time_curr (time_curr),
        .advance   (advance),
        .done      (done),
        .state     (state)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [31:0] t [4];
        logic [3:0]  en;
        logic [31:0] e_next;
        logic [1:0]  e_idx;
        logic        e_any;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < N; i++) time_in[i] = v;
    endtask

    task automatic set_vec(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [3:0] en,
                           input logic [31:0] nx, input logic [1:0] ix, input logic an);
        vecs[k].t[0] = a; vecs[k].t[1] = b; vecs[k].t[2] = c; vecs[k].t[3] = d;
        vecs[k].en = en; vecs[k].e_next = nx; vecs[k].e_idx = ix; vecs[k].e_any = an;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Reference minimum: scan channels in order, strictly smaller wins.
    task automatic ref_min(output logic [31:0] mn, output logic [1:0] ix, output logic an);
        mn = 32'hFFFF_FFFF; ix = 2'd0; an = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (chan_en[i]) begin
                an = 1'b1;
                if (time_in[i] < mn) begin
                    mn = time_in[i];
                    ix = 2'(i);
                end
            end
        end
    endtask

    initial begin
        int          adv_count;
        int          m_mode;
        logic [31:0] m_curr;
        logic        m_adv;
        logic        m_upd;
        logic [31:0] mn;
        logic [1:0]  ix;
        logic        an;
        logic        r_in;

        set_all(32'd0);
        chan_en   = '1;
        stop_time = 32'd100;

        // Reset / idle
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("reset_time_curr", time_curr, 0);
        chk("reset_advance", 32'(advance), 0);
        chk("reset_state", 32'(state), 0);
        chk("reset_done", 32'(done), 0);

        // Reduction table
        set_vec(0, 40, 10, 10, 30, 4'b1111, 10, 1, 1);
        set_vec(1, 40, 10, 10, 30, 4'b1101, 10, 2, 1);
        set_vec(2, 40, 10, 10, 30, 4'b0000, 32'hFFFF_FFFF, 0, 0);
        set_vec(3, 5, 5, 5, 5, 4'b1111, 5, 0, 1);
        set_vec(4, 7, 9, 3, 3, 4'b0011, 7, 0, 1);
        set_vec(5, 100, 50, 60, 20, 4'b1000, 20, 3, 1);
        set_vec(6, 8, 6, 9, 6, 4'b1110, 6, 1, 1);
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < N; i++) time_in[i] = vecs[k].t[i];
            chan_en = vecs[k].en;
            #1;
            chk($sformatf("vec%0d_time_next", k), time_next, vecs[k].e_next);
            chk($sformatf("vec%0d_next_idx", k), 32'(next_idx), 32'(vecs[k].e_idx));
            chk($sformatf("vec%0d_any_en", k), 32'(any_en), 32'(vecs[k].e_any));
            tick();
            chk($sformatf("vec%0d_idle_no_update", k), time_curr, 0);
        end

        // Run to stop_time
        chan_en = '1;
        stop_time = 32'd100;
        run = 1'b1;
        tick();
        chk("run_enter_state", 32'(state), 1);
        chk("run_enter_no_update", time_curr, 0);
        for (int k = 1; k <= 4; k++) begin
            set_all(32'(25 * k));
            tick();
            chk($sformatf("ramp%0d_time_curr", k), time_curr, 32'(25 * k));
            chk($sformatf("ramp%0d_advance", k), 32'(advance), 1);
        end
        chk("stop_state", 32'(state), 3);
        chk("stop_done", 32'(done), 1);
        set_all(32'd200);
        tick();
        chk("done_hold_time", time_curr, 100);
        chk("done_hold_adv", 32'(advance), 0);
        chk("done_hold_state", 32'(state), 3);

        // IDLE step goes to PAUSE without an update
        do_reset();
        stop_time = 32'd1000;
        set_all(32'd5);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("idle_step_state", 32'(state), 2);
        chk("idle_step_no_adv", 32'(advance), 0);
        chk("idle_step_no_time", time_curr, 0);

        // Pause / step
        do_reset();
        set_all(32'd10);
        run = 1'b1;
        tick();
        tick();
        chk("ps_run_time", time_curr, 10);
        run = 1'b0;
        set_all(32'd20);
        tick();
        chk("ps_pause_state", 32'(state), 2);
        chk("ps_pause_no_update", time_curr, 10);
        chk("ps_pause_no_adv", 32'(advance), 0);
        adv_count = 0;
        for (int s = 0; s < 3; s++) begin
            set_all(32'(30 + 10 * s));
            step = 1'b1;
            tick();
            step = 1'b0;
            adv_count += int'(advance);
            chk($sformatf("step%0d_time", s), time_curr, 32'(30 + 10 * s));
            tick();
            adv_count += int'(advance);
            chk($sformatf("step%0d_state", s), 32'(state), 2);
        end
        chk("step_adv_count", 32'(adv_count), 3);
        step = 1'b1;
        run = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_all(32'(100 + c));
            tick();
            chk($sformatf("steprun%0d_state", c), 32'(state), 1);
            chk($sformatf("steprun%0d_adv", c), 32'(advance), 1);
            chk($sformatf("steprun%0d_time", c), time_curr, 32'(100 + c));
        end
        step = 1'b0;

        // Mid-operation reset
        set_all(32'd75);
        tick();
        chk("midrst_pre_time", time_curr, 75);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_time", time_curr, 0);
        chk("midrst_state", 32'(state), 0);
        chk("midrst_adv", 32'(advance), 0);
        chk("midrst_done", 32'(done), 0);

        // No channels enabled: no update while running
        tick();
        set_all(32'd40);
        tick();
        chk("noen_pre_time", time_curr, 40);
        chan_en = '0;
        #1;
        chk("noen_time_next", time_next, 32'hFFFF_FFFF);
        chk("noen_any", 32'(any_en), 0);
        tick();
        chk("noen_adv", 32'(advance), 0);
        chk("noen_time", time_curr, 40);
        chk("noen_state", 32'(state), 1);

        // Randomized traffic against the model
        do_reset();
        stop_time = 32'd60;
        m_mode = 0; m_curr = 0; m_adv = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r_in = ($urandom_range(0, 39) == 0);
            rst  = r_in;
            run  = ($urandom_range(0, 3) != 0);
            step = ($urandom_range(0, 2) == 0);
            chan_en = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) time_in[i] = 32'($urandom_range(0, 63));
            #1;
            ref_min(mn, ix, an);
            chk("rnd_time_next", time_next, mn);
            chk("rnd_next_idx", 32'(next_idx), 32'(ix));
            chk("rnd_any_en", 32'(any_en), 32'(an));
            if (r_in) begin
                m_mode = 0; m_curr = 0; m_adv = 0;
            end else begin
                m_upd = an && ((m_mode == 1 && run) || (m_mode == 2 && step));
                m_adv = m_upd;
                if (m_upd) m_curr = mn;
                if (m_upd && mn >= stop_time) m_mode = 3;
                else if (m_mode == 0) m_mode = run ? 1 : (step ? 2 : 0);
                else if (m_mode == 1 && !run) m_mode = 2;
                else if (m_mode == 2 && run) m_mode = 1;
            end
            tick();
            chk("rnd_state", 32'(state), 32'(m_mode));
            chk("rnd_time_curr", time_curr, m_curr);
            chk("rnd_advance", 32'(advance), 32'(m_adv));
            chk("rnd_done", 32'(done), (m_mode == 3) ? 32'd1 : 32'd0);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
